// File: rtl/scene_pkg.sv
// Shared scene/fade types and the per-channel brightness scaling helper
// for the background compositor.
package scene_pkg;

  typedef enum logic [1:0] {
    SCENE_MENU   = 2'd0,
    SCENE_LEVEL  = 2'd1,
    SCENE_RESULT = 2'd2
  } scene_t;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    SWAP,
    FADE_IN
  } fade_state_t;

  localparam logic [3:0] LVL_MAX = 4'd15;
  localparam int IMG_W = 320;
  localparam int IMG_H = 240;

  // (c * (lvl+1)) >> 4 on a 9-bit product
  function automatic logic [3:0] scale_ch(
    input logic [3:0] c,
    input logic [3:0] lvl
  );
    logic [4:0] l1;
    logic [8:0] p;
    l1 = {1'b0, lvl} + 5'd1;
    p  = {5'd0, c} * {4'd0, l1};
    return p[7:4];
  endfunction

endpackage

// File: rtl/scene_compositor_fade_scaler.sv
// Combinational RGB444 brightness scaler; lvl=15 is unity, lvl=0 is black.
module fade_scaler
  import scene_pkg::*;
(
  input  logic [11:0] i_rgb,
  input  logic [3:0]  i_lvl,
  output logic [11:0] o_rgb
);

  assign o_rgb = {scale_ch(i_rgb[11:8], i_lvl),
                  scale_ch(i_rgb[7:4],  i_lvl),
                  scale_ch(i_rgb[3:0],  i_lvl)};

endmodule

// File: rtl/scene_compositor.sv
// Background pixel path: ROM addressing, scene select, frame-timed
// fade-out/swap/fade-in and sync re-alignment to the ROM latency.
module scene_compositor
  import scene_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 2,
  parameter int RESET_SCENE     = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        vid_on,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [1:0]  scene_req,
  output logic [9:0]  ADDR_X,
  output logic [9:0]  ADDR_Y,
  input  logic [11:0] menu_pic,
  input  logic [11:0] level_pic,
  input  logic [11:0] result_pic,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [1:0]  scene_cur,
  output logic        busy
);

  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);
  localparam scene_t RST_SCENE = scene_t'(RESET_SCENE[1:0]);

  fade_state_t r_state;
  scene_t      r_scene;
  scene_t      r_target;
  logic [3:0]  r_lvl;
  logic [CW-1:0] r_cnt;
  logic        r_hs1;
  logic        r_vs1;
  logic        r_von1;

  logic        w_tick;
  logic        w_step;
  logic [11:0] w_pix;
  logic [11:0] w_scaled;

  assign ADDR_X = vid_on ? {1'b0, DrawX[9:1]} : 10'd0;
  assign ADDR_Y = vid_on ? {1'b0, DrawY[9:1]} : 10'd0;

  // r_vs1 doubles as the previous vs_in sample for edge detection
  assign w_tick = r_vs1 & ~vs_in;
  assign w_step = w_tick && (r_cnt == CNT_LAST);

  assign scene_cur = r_scene;
  assign busy      = (r_state != IDLE);

  always_comb begin
    w_pix = menu_pic;
    case (r_scene)
      SCENE_LEVEL:  w_pix = level_pic;
      SCENE_RESULT: w_pix = result_pic;
      default:      w_pix = menu_pic;
    endcase
  end

  fade_scaler u_scaler (
    .i_rgb (w_pix),
    .i_lvl (r_lvl),
    .o_rgb (w_scaled)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_von1 <= 1'b0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
      VGA_R  <= 4'd0;
      VGA_G  <= 4'd0;
      VGA_B  <= 4'd0;
    end else begin
      r_hs1  <= hs_in;
      r_vs1  <= vs_in;
      r_von1 <= vid_on;
      VGA_HS <= r_hs1;
      VGA_VS <= r_vs1;
      {VGA_R, VGA_G, VGA_B} <= r_von1 ? w_scaled : 12'd0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_lvl    <= LVL_MAX;
      r_scene  <= RST_SCENE;
      r_target <= RST_SCENE;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (scene_req != 2'd3 && scene_req != r_scene) begin
            r_target <= scene_t'(scene_req);
            r_cnt    <= '0;
            r_state  <= FADE_OUT;
          end
        end
        FADE_OUT: begin
          if (w_step) begin
            r_cnt <= '0;
            r_lvl <= r_lvl - 4'd1;
            if (r_lvl == 4'd1) r_state <= SWAP;
          end else if (w_tick) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SWAP: begin
          r_scene <= r_target;
          r_cnt   <= '0;
          r_state <= FADE_IN;
        end
        FADE_IN: begin
          if (w_step) begin
            r_cnt <= '0;
            r_lvl <= r_lvl + 4'd1;
            if (r_lvl == LVL_MAX - 4'd1) r_state <= IDLE;
          end else if (w_tick) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scene_compositor.sv
// Randomized self-checking bench for scene_compositor against a
// tick-count based reference model of the fade sequence.
module tb_scene_compositor;

  localparam int FPS = 2;
  localparam int OUT_TICKS = 15 * FPS;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        vid_on, hs_in, vs_in;
  logic [1:0]  scene_req;
  logic [9:0]  ADDR_X, ADDR_Y;
  logic [11:0] menu_pic, level_pic, result_pic;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS;
  logic [1:0]  scene_cur;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  scene_compositor #(.FRAMES_PER_STEP(FPS), .RESET_SCENE(0)) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .vid_on(vid_on), .hs_in(hs_in), .vs_in(vs_in),
    .scene_req(scene_req), .ADDR_X(ADDR_X), .ADDR_Y(ADDR_Y),
    .menu_pic(menu_pic), .level_pic(level_pic),
    .result_pic(result_pic), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .scene_cur(scene_cur), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Reference model: a transition is 30*FPS frame ticks; brightness is
  // derived from how many ticks have elapsed, swap happens at black.
  bit          m_busy, m_swapped, m_pend;
  int          m_k;
  logic [1:0]  m_scene, m_target;
  logic        m_prev_vs, m_von_d1, m_hs_d1, m_vs_d1;
  logic [11:0] exp_rgb;
  logic        exp_hs, exp_vs;

  function automatic int m_lvl();
    if (!m_busy) return 15;
    if (!m_swapped) return 15 - m_k / FPS;
    return (m_k - OUT_TICKS) / FPS;
  endfunction

  function automatic logic [11:0] ref_px(input logic [11:0] p, input int l);
    int r, g, b;
    r = (int'(p[11:8]) * (l + 1)) / 16;
    g = (int'(p[7:4])  * (l + 1)) / 16;
    b = (int'(p[3:0])  * (l + 1)) / 16;
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  always @(posedge Clk) begin : mdl
    bit tick;
    logic [11:0] px;
    if (Reset) begin
      m_busy = 0; m_swapped = 0; m_pend = 0; m_k = 0;
      m_scene = 2'd0; m_target = 2'd0;
      m_prev_vs = 1; m_von_d1 = 0; m_hs_d1 = 1; m_vs_d1 = 1;
      exp_rgb = 12'd0; exp_hs = 1; exp_vs = 1;
    end else begin
      px = (m_scene == 2'd0) ? menu_pic :
           (m_scene == 2'd1) ? level_pic : result_pic;
      exp_rgb = m_von_d1 ? ref_px(px, m_lvl()) : 12'd0;
      exp_hs = m_hs_d1;
      exp_vs = m_vs_d1;
      tick = m_prev_vs && !vs_in;
      if (!m_busy) begin
        if (scene_req != 2'd3 && scene_req != m_scene) begin
          m_busy = 1; m_target = scene_req; m_k = 0; m_swapped = 0;
        end
      end else if (m_pend) begin
        m_scene = m_target; m_pend = 0; m_swapped = 1;
      end else if (tick) begin
        m_k++;
        if (!m_swapped && m_k == OUT_TICKS) m_pend = 1;
        if (m_swapped && m_k == 2 * OUT_TICKS) m_busy = 0;
      end
      m_von_d1 = vid_on; m_hs_d1 = hs_in;
      m_vs_d1 = vs_in; m_prev_vs = vs_in;
    end
  end

  task automatic test_reset();
    Reset = 1; DrawX = 0; DrawY = 0; vid_on = 0; hs_in = 1; vs_in = 1;
    scene_req = 0; menu_pic = 0; level_pic = 0; result_pic = 0;
    repeat (2) @(negedge Clk);
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, busy, scene_cur} !== 17'b11000)
      $display("FAIL reset: rgb=%h hs=%b vs=%b busy=%b scene=%0d, need 000/1/1/0/0",
               {VGA_R, VGA_G, VGA_B}, VGA_HS, VGA_VS, busy, scene_cur);
    else n_pass++;
    Reset = 0;
  endtask

  task automatic test_addr_pixel();
    @(negedge Clk);
    DrawX = 10'd100; DrawY = 10'd51; vid_on = 1;
    #1;
    n_checks++;
    if (ADDR_X !== 10'd50 || ADDR_Y !== 10'd25)
      $display("FAIL addr_fixed: got %0d,%0d need 50,25", ADDR_X, ADDR_Y);
    else n_pass++;
    @(negedge Clk);
    menu_pic = 12'hF84;
    @(negedge Clk);
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 12'hF84)
      $display("FAIL pix_fixed: got %h need f84", {VGA_R, VGA_G, VGA_B});
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      DrawX = 10'($urandom_range(0, 639));
      DrawY = 10'($urandom_range(0, 479));
      vid_on = 1'($urandom);
      menu_pic = 12'($urandom); level_pic = 12'($urandom);
      result_pic = 12'($urandom);
      #1;
      n_checks++;
      if (ADDR_X !== (vid_on ? DrawX / 2 : 10'd0) ||
          ADDR_Y !== (vid_on ? DrawY / 2 : 10'd0))
        $display("FAIL addr_rand: got %0d,%0d for x=%0d y=%0d von=%b",
                 ADDR_X, ADDR_Y, DrawX, DrawY, vid_on);
      else n_pass++;
      @(negedge Clk);
      n_checks++;
      if ({VGA_R, VGA_G, VGA_B} !== exp_rgb)
        $display("FAIL pix_rand: got %h need %h", {VGA_R, VGA_G, VGA_B}, exp_rgb);
      else n_pass++;
    end
  endtask

  task automatic test_blank_sync();
    vid_on = 0; menu_pic = 12'hFFF;
    for (int i = 0; i < 30; i++) begin
      hs_in = 1'($urandom); vs_in = 1'($urandom);
      @(negedge Clk);
      n_checks++;
      if (VGA_HS !== exp_hs || VGA_VS !== exp_vs)
        $display("FAIL sync_delay: hs=%b vs=%b need %b %b",
                 VGA_HS, VGA_VS, exp_hs, exp_vs);
      else n_pass++;
      if (i >= 2) begin
        n_checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000)
          $display("FAIL blank: got %h need 000", {VGA_R, VGA_G, VGA_B});
        else n_pass++;
      end
    end
    hs_in = 1; vs_in = 1;
    @(negedge Clk);
  endtask

  task automatic test_transition();
    bit do7 = 0, done7 = 0, ended = 0;
    vid_on = 1; scene_req = 2'd1;
    for (int i = 0; i < 3000 && !ended; i++) begin
      vs_in = (i % 8) != 3;
      hs_in = (i % 4) != 0;
      DrawX = 10'($urandom_range(0, 639));
      menu_pic = 12'($urandom); level_pic = 12'($urandom);
      result_pic = 12'($urandom);
      if (!done7 && m_busy && !m_swapped && !m_pend && m_lvl() == 7) begin
        menu_pic = 12'hFFF; do7 = 1; done7 = 1;
      end
      @(negedge Clk);
      if (do7) begin
        do7 = 0;
        n_checks++;
        if (VGA_R !== 4'd7)
          $display("FAIL lvl7: got %0d need 7", VGA_R);
        else n_pass++;
      end
      n_checks++;
      if (busy !== m_busy || scene_cur !== m_scene ||
          {VGA_R, VGA_G, VGA_B} !== exp_rgb)
        $display("FAIL fade: busy=%b scene=%0d rgb=%h need %b %0d %h",
                 busy, scene_cur, {VGA_R, VGA_G, VGA_B}, m_busy, m_scene, exp_rgb);
      else n_pass++;
      ended = (i > 4) && !m_busy;
    end
    n_checks++;
    if (!done7 || busy !== 1'b0 || scene_cur !== 2'd1)
      $display("FAIL fade_end: lvl7_seen=%b busy=%b scene=%0d need 1 0 1",
               done7, busy, scene_cur);
    else n_pass++;
    level_pic = 12'hABC;
    repeat (2) @(negedge Clk);
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 12'hABC)
      $display("FAIL unscaled: got %h need abc", {VGA_R, VGA_G, VGA_B});
    else n_pass++;
  endtask

  task automatic test_reserved();
    scene_req = 2'd3;
    for (int i = 0; i < 60; i++) begin
      vs_in = (i % 8) != 3;
      @(negedge Clk);
      n_checks++;
      if (busy !== 1'b0 || scene_cur !== 2'd1)
        $display("FAIL reserved: busy=%b scene=%0d need 0 1", busy, scene_cur);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit saw_idle1 = 0, ended = 0;
    Reset = 1; scene_req = 2'd1;
    @(negedge Clk);
    Reset = 0;
    for (int i = 0; i < 4000 && !ended; i++) begin
      vs_in = (i % 8) != 3;
      if (i == 20) scene_req = 2'd2;
      menu_pic = 12'($urandom); level_pic = 12'($urandom);
      result_pic = 12'($urandom);
      @(negedge Clk);
      if (scene_cur === 2'd1 && busy === 1'b0) saw_idle1 = 1;
      n_checks++;
      if (busy !== m_busy || scene_cur !== m_scene ||
          {VGA_R, VGA_G, VGA_B} !== exp_rgb)
        $display("FAIL chain: busy=%b scene=%0d rgb=%h need %b %0d %h",
                 busy, scene_cur, {VGA_R, VGA_G, VGA_B}, m_busy, m_scene, exp_rgb);
      else n_pass++;
      ended = (m_scene == 2'd2) && !m_busy;
    end
    n_checks++;
    if (!saw_idle1 || scene_cur !== 2'd2 || busy !== 1'b0)
      $display("FAIL chain_end: idle_on_1=%b scene=%0d busy=%b need 1 2 0",
               saw_idle1, scene_cur, busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    scene_req = 2'd1;
    for (int i = 0; i < 4000 && !hit; i++) begin
      vs_in = (i % 8) != 3;
      @(negedge Clk);
      hit = m_swapped && m_busy && m_lvl() == 5;
    end
    n_checks++;
    if (!hit || busy !== 1'b1)
      $display("FAIL mid_reach: reached=%b busy=%b need 1 1", hit, busy);
    else n_pass++;
    Reset = 1; scene_req = 2'd0; vs_in = 1;
    @(negedge Clk);
    Reset = 0;
    n_checks++;
    if (busy !== 1'b0 || scene_cur !== 2'd0)
      $display("FAIL mid_reset: busy=%b scene=%0d need 0 0", busy, scene_cur);
    else n_pass++;
    vid_on = 1;
    for (int i = 0; i < 6; i++) begin
      menu_pic = 12'($urandom);
      @(negedge Clk);
      if (i >= 1) begin
        n_checks++;
        if ({VGA_R, VGA_G, VGA_B} !== exp_rgb || busy !== 1'b0)
          $display("FAIL post_reset: rgb=%h busy=%b need %h 0",
                   {VGA_R, VGA_G, VGA_B}, busy, exp_rgb);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_addr_pixel();
    test_blank_sync();
    test_transition();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
